// File: rtl/ex_stage_pkg.sv
// Shared execute-stage definitions.
// Opcodes, load/store codes, stall bit positions.
package ex_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [5:0] EXE_NOP_OP   = 6'd0;
  localparam logic [5:0] EXE_ADD_OP   = 6'd1;
  localparam logic [5:0] EXE_ADDU_OP  = 6'd2;
  localparam logic [5:0] EXE_SUB_OP   = 6'd3;
  localparam logic [5:0] EXE_SUBU_OP  = 6'd4;
  localparam logic [5:0] EXE_AND_OP   = 6'd5;
  localparam logic [5:0] EXE_OR_OP    = 6'd6;
  localparam logic [5:0] EXE_XOR_OP   = 6'd7;
  localparam logic [5:0] EXE_NOR_OP   = 6'd8;
  localparam logic [5:0] EXE_SLL_OP   = 6'd9;
  localparam logic [5:0] EXE_SRL_OP   = 6'd10;
  localparam logic [5:0] EXE_SRA_OP   = 6'd11;
  localparam logic [5:0] EXE_SLT_OP   = 6'd12;
  localparam logic [5:0] EXE_SLTU_OP  = 6'd13;
  localparam logic [5:0] EXE_LUI_OP   = 6'd14;
  localparam logic [5:0] EXE_MTHI_OP  = 6'd15;
  localparam logic [5:0] EXE_MTLO_OP  = 6'd16;
  localparam logic [5:0] EXE_MFHI_OP  = 6'd17;
  localparam logic [5:0] EXE_MFLO_OP  = 6'd18;
  localparam logic [5:0] EXE_MULT_OP  = 6'd19;
  localparam logic [5:0] EXE_MULTU_OP = 6'd20;
  localparam logic [5:0] EXE_DIV_OP   = 6'd21;
  localparam logic [5:0] EXE_DIVU_OP  = 6'd22;

  localparam logic [3:0] LS_NONE = 4'd0;
  localparam logic [3:0] LS_LB   = 4'd1;
  localparam logic [3:0] LS_LBU  = 4'd2;
  localparam logic [3:0] LS_LH   = 4'd3;
  localparam logic [3:0] LS_LHU  = 4'd4;
  localparam logic [3:0] LS_LW   = 4'd5;
  localparam logic [3:0] LS_SB   = 4'd6;
  localparam logic [3:0] LS_SH   = 4'd7;
  localparam logic [3:0] LS_SW   = 4'd8;

  localparam int STALL_PC     = 0;
  localparam int STALL_IF_ID  = 1;
  localparam int STALL_ID_EX  = 2;
  localparam int STALL_EX_MEM = 3;
  localparam int STALL_MEM_WB = 4;
  localparam int STALL_WB     = 5;

  function automatic logic [31:0] sext16(
    input logic [15:0] v
  );
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/ex_stage_div_unit.sv
// Radix-2 restoring divider for DIV/DIVU.
// Magnitudes are divided; signs fixed on output.
module div_unit
  import ex_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        release_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  localparam int CW =
    (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_e;

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   quot_q, quot_d;
  logic [31:0]   rem_q, rem_d;
  logic [31:0]   dvsr_q, dvsr_d;
  logic          negq_q, negq_d;
  logic          negr_q, negr_d;
  logic [32:0]   shifted;
  logic [32:0]   diff;

  // state register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dvsr_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dvsr_q  <= dvsr_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  // next state: operand load, shift-subtract, release
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    shifted = {rem_q, quot_q[31]};
    diff    = shifted - {1'b0, dvsr_q};
    unique case (state_q)
      DIV_IDLE: begin
        if (start_i) begin
          cnt_d = '0;
          if (b_i == '0) begin
            quot_d  = '1;
            rem_d   = a_i;
            dvsr_d  = '0;
            negq_d  = 1'b0;
            negr_d  = 1'b0;
            state_d = DIV_DONE;
          end else begin
            quot_d  = (signed_i && a_i[31])
                      ? -a_i : a_i;
            dvsr_d  = (signed_i && b_i[31])
                      ? -b_i : b_i;
            rem_d   = '0;
            negq_d  = signed_i
                      && (a_i[31] ^ b_i[31]);
            negr_d  = signed_i && a_i[31];
            state_d = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        if (!diff[32]) begin
          rem_d  = diff[31:0];
          quot_d = {quot_q[30:0], 1'b1};
        end else begin
          rem_d  = shifted[31:0];
          quot_d = {quot_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        if (release_i) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  assign busy_o = (state_q == DIV_BUSY)
               || (state_q == DIV_IDLE && start_i);
  assign done_o = (state_q == DIV_DONE);
  assign quot_o = negq_q ? -quot_q : quot_q;
  assign rem_o  = negr_q ? -rem_q : rem_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, address gen, HI/LO.
// Divides run in div_unit and stall the front.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  ex_aluop,
  input  logic [31:0] ex_reg1,
  input  logic [31:0] ex_reg2,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_inst,
  input  logic [3:0]  ex_lsop,
  input  logic [5:0]  stall,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  lsop_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] store_data_o,
  output logic        stallreq_o
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] alu_res;

  logic               mul_sgn;
  logic signed [32:0] mul_a, mul_b;
  logic signed [65:0] mul_p;

  logic        is_div;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_q, div_r;
  logic        unused_bits;

  assign mul_sgn = (ex_aluop == EXE_MULT_OP);
  assign mul_a   = {mul_sgn & ex_reg1[31], ex_reg1};
  assign mul_b   = {mul_sgn & ex_reg2[31], ex_reg2};
  assign mul_p   = 66'(mul_a) * 66'(mul_b);

  assign is_div = (ex_aluop == EXE_DIV_OP)
               || (ex_aluop == EXE_DIVU_OP);

  div_unit #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (is_div),
    .signed_i (ex_aluop == EXE_DIV_OP),
    .a_i      (ex_reg1),
    .b_i      (ex_reg2),
    .release_i(!stall[STALL_ID_EX]),
    .busy_o   (div_busy),
    .done_o   (div_done),
    .quot_o   (div_q),
    .rem_o    (div_r)
  );

  // single-cycle ALU and HI/LO reads
  always_comb begin
    alu_res = '0;
    unique case (1'b1)
      (ex_aluop == EXE_ADD_OP),
      (ex_aluop == EXE_ADDU_OP):
        alu_res = ex_reg1 + ex_reg2;
      (ex_aluop == EXE_SUB_OP),
      (ex_aluop == EXE_SUBU_OP):
        alu_res = ex_reg1 - ex_reg2;
      (ex_aluop == EXE_AND_OP):
        alu_res = ex_reg1 & ex_reg2;
      (ex_aluop == EXE_OR_OP):
        alu_res = ex_reg1 | ex_reg2;
      (ex_aluop == EXE_XOR_OP):
        alu_res = ex_reg1 ^ ex_reg2;
      (ex_aluop == EXE_NOR_OP):
        alu_res = ~(ex_reg1 | ex_reg2);
      (ex_aluop == EXE_SLL_OP):
        alu_res = ex_reg2 << ex_reg1[4:0];
      (ex_aluop == EXE_SRL_OP):
        alu_res = ex_reg2 >> ex_reg1[4:0];
      (ex_aluop == EXE_SRA_OP):
        alu_res = $signed(ex_reg2)
                  >>> ex_reg1[4:0];
      (ex_aluop == EXE_SLT_OP):
        alu_res = {31'b0, $signed(ex_reg1)
                          < $signed(ex_reg2)};
      (ex_aluop == EXE_SLTU_OP):
        alu_res = {31'b0, ex_reg1 < ex_reg2};
      (ex_aluop == EXE_LUI_OP):
        alu_res = {ex_reg2[15:0], 16'h0000};
      (ex_aluop == EXE_MFHI_OP):
        alu_res = hi_q;
      (ex_aluop == EXE_MFLO_OP):
        alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // HI/LO write selection; divider result wins
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (div_done) begin
      hi_d = div_r;
      lo_d = div_q;
    end else begin
      unique case (1'b1)
        (ex_aluop == EXE_MTHI_OP):
          hi_d = ex_reg1;
        (ex_aluop == EXE_MTLO_OP):
          lo_d = ex_reg1;
        (ex_aluop == EXE_MULT_OP),
        (ex_aluop == EXE_MULTU_OP): begin
          hi_d = mul_p[63:32];
          lo_d = mul_p[31:0];
        end
        default: ;
      endcase
    end
  end

  // HI/LO commit only while EX/MEM advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (!stall[STALL_EX_MEM]) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign wd_o         = ex_wd;
  assign wreg_o       = ex_wreg
                     && (ex_aluop != EXE_NOP_OP);
  assign wdata_o      = alu_res;
  assign lsop_o       = ex_lsop;
  assign store_data_o = ex_reg2;
  assign mem_addr_o   = ex_reg1
                     + sext16(ex_inst[15:0]);
  assign stallreq_o   = div_busy && rst_n;

  assign unused_bits = ^{ex_inst[31:16],
                         stall[5:4], stall[1:0],
                         mul_p[65:64]};

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage.
// Reference model kept at the arithmetic level.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  ex_aluop = '0;
  logic [31:0] ex_reg1 = '0, ex_reg2 = '0;
  logic [4:0]  ex_wd = '0;
  logic        ex_wreg = 1'b0;
  logic [31:0] ex_inst = '0;
  logic [3:0]  ex_lsop = '0;
  logic [5:0]  stall;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic [3:0]  lsop_o;
  logic [31:0] mem_addr_o;
  logic [31:0] store_data_o;
  logic        stallreq_o;

  always #5 clk = ~clk;

  // controller: a stall request holds stages 0-3
  assign stall = {2'b00, {4{stallreq_o}}};

  ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ex_aluop(ex_aluop),
    .ex_reg1(ex_reg1), .ex_reg2(ex_reg2),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg),
    .ex_inst(ex_inst), .ex_lsop(ex_lsop),
    .stall(stall),
    .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .lsop_o(lsop_o),
    .mem_addr_o(mem_addr_o),
    .store_data_o(store_data_o),
    .stallreq_o(stallreq_o)
  );

  typedef struct packed {
    logic [31:0] wdata;
    logic [4:0]  wd;
    logic        wreg;
    logic [3:0]  lsop;
    logic [31:0] addr;
    logic [31:0] sdata;
  } exp_t;

  exp_t        sb[$];
  logic        in_valid = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  nm, got, exp);
  endtask

  function automatic logic [31:0] ref_result(
    input logic [5:0] op,
    input logic [31:0] a, input logic [31:0] b);
    int sa, sb2;
    sa = a; sb2 = b;
    case (op)
      EXE_ADD_OP, EXE_ADDU_OP: return a + b;
      EXE_SUB_OP, EXE_SUBU_OP: return a - b;
      EXE_AND_OP:  return a & b;
      EXE_OR_OP:   return a | b;
      EXE_XOR_OP:  return a ^ b;
      EXE_NOR_OP:  return ~(a | b);
      EXE_SLL_OP:  return b << (a % 32);
      EXE_SRL_OP:  return b >> (a % 32);
      EXE_SRA_OP:  return 32'(sb2 >>> (a % 32));
      EXE_SLT_OP:  return (sa < sb2) ? 1 : 0;
      EXE_SLTU_OP: return (a < b) ? 1 : 0;
      EXE_LUI_OP:  return (b % 65536) * 65536;
      EXE_MFHI_OP: return hi_m;
      EXE_MFLO_OP: return lo_m;
      default:     return 0;
    endcase
  endfunction

  task automatic ref_commit(input logic [5:0] op,
                            input logic [31:0] a,
                            input logic [31:0] b);
    longint p;
    longint unsigned pu;
    int sa, sb2;
    sa = a; sb2 = b;
    case (op)
      EXE_MTHI_OP: hi_m = a;
      EXE_MTLO_OP: lo_m = a;
      EXE_MULT_OP: begin
        p = longint'(sa) * longint'(sb2);
        {hi_m, lo_m} = 64'(p);
      end
      EXE_MULTU_OP: begin
        pu = longint'(a) * longint'(b);
        {hi_m, lo_m} = pu;
      end
      EXE_DIV_OP, EXE_DIVU_OP: begin
        if (b == 0) begin
          lo_m = 32'hFFFF_FFFF;
          hi_m = a;
        end else if (op == EXE_DIV_OP) begin
          lo_m = 32'(sa / sb2);
          hi_m = 32'(sa % sb2);
        end else begin
          lo_m = a / b;
          hi_m = a % b;
        end
      end
      default: ;
    endcase
  endtask

  // issue one instruction, hold it while stalled
  task automatic issue(input logic [5:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [3:0] ls,
                       input logic [15:0] imm);
    exp_t e;
    int   stalls, exp_st;
    logic [4:0] wd;
    logic wr;
    wd = 5'($urandom);
    wr = 1'($urandom);
    @(posedge clk); #1;
    e.wdata = ref_result(op, a, b);
    e.wd    = wd;
    e.wreg  = wr && (op != EXE_NOP_OP);
    e.lsop  = ls;
    e.addr  = a + {{16{imm[15]}}, imm};
    e.sdata = b;
    sb.push_back(e);
    exp_st = 0;
    if (op == EXE_DIV_OP || op == EXE_DIVU_OP)
      exp_st = (b == 0) ? 1 : 33;
    ref_commit(op, a, b);
    ex_aluop = op; ex_reg1 = a; ex_reg2 = b;
    ex_wd = wd; ex_wreg = wr; ex_lsop = ls;
    ex_inst = {16'hABCD, imm};
    in_valid = 1'b1;
    stalls = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!stallreq_o) break;
      stalls++;
    end
    chk("stall_cycles", 64'(stalls), 64'(exp_st));
  endtask

  // monitor: instruction leaves EX when not stalled
  always @(negedge clk) begin
    exp_t e, g;
    if (rst_n && in_valid && !stallreq_o) begin
      g = '{wdata_o, wd_o, wreg_o, lsop_o,
            mem_addr_o, store_data_o};
      n_chk++;
      if (sb.size() == 0) begin
        $display("FAIL sb_underflow: got %h", g);
      end else begin
        e = sb.pop_front();
        if (g === e) n_pass++;
        else $display(
          "FAIL ex_out: got %h expected %h", g, e);
      end
    end
  end

  logic [5:0] rops [0:21];
  initial begin
    logic [5:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 22; i++) rops[i] = 6'(i + 1);
    #3;
    chk("reset_stallreq", 64'(stallreq_o), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(EXE_MFHI_OP, 0, 0, LS_NONE, 0);
    issue(EXE_MFLO_OP, 0, 0, LS_NONE, 0);
    issue(EXE_ADD_OP, 32'h7FFF_FFFF, 1, LS_NONE, 0);
    issue(EXE_SLT_OP, 32'hFFFF_FFFF, 1, LS_NONE, 0);
    issue(EXE_SLTU_OP, 32'hFFFF_FFFF, 1, LS_NONE, 0);
    issue(EXE_ADDU_OP, 32'h1000, 0, LS_LW, 16'hFFFC);
    issue(EXE_NOP_OP, 5, 6, LS_NONE, 0);
    issue(EXE_MULT_OP, 32'hFFFF_FFFD, 5, LS_NONE, 0);
    issue(EXE_MFHI_OP, 0, 0, LS_NONE, 0);
    issue(EXE_MFLO_OP, 0, 0, LS_NONE, 0);
    issue(EXE_DIV_OP, 32'hFFFF_FFF9, 2, LS_NONE, 0);
    issue(EXE_MFHI_OP, 0, 0, LS_NONE, 0);
    issue(EXE_MFLO_OP, 0, 0, LS_NONE, 0);
    issue(EXE_DIVU_OP, 100, 0, LS_NONE, 0);
    issue(EXE_MFLO_OP, 0, 0, LS_NONE, 0);
    issue(EXE_MFHI_OP, 0, 0, LS_NONE, 0);

    for (int n = 0; n < 220; n++) begin
      op = rops[$urandom_range(0, 21)];
      a = ($urandom_range(0, 3) == 0)
          ? 32'($urandom_range(0, 40)) : $urandom;
      b = ($urandom_range(0, 3) == 0)
          ? 32'($urandom_range(0, 40)) : $urandom;
      if ((op == EXE_DIV_OP || op == EXE_DIVU_OP)
          && $urandom_range(0, 4) == 0) b = 0;
      if (op == EXE_DIV_OP && a == 32'h8000_0000
          && b == 32'hFFFF_FFFF) b = 3;
      issue(op, a, b, 4'($urandom),
            16'($urandom));
    end

    issue(EXE_MTHI_OP, 32'h1234_5678, 0, LS_NONE, 0);
    issue(EXE_MTLO_OP, 32'h9ABC_DEF0, 0, LS_NONE, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    ex_aluop = EXE_DIVU_OP;
    ex_reg1 = 1000; ex_reg2 = 7;
    repeat (11) @(negedge clk);
    @(posedge clk); #2;
    chk("busy_before_rst", 64'(stallreq_o), 1);
    rst_n = 1'b0;
    #1;
    chk("stallreq_in_rst", 64'(stallreq_o), 0);
    ex_aluop = EXE_NOP_OP;
    hi_m = '0; lo_m = '0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    issue(EXE_MFHI_OP, 0, 0, LS_NONE, 0);
    issue(EXE_MFLO_OP, 0, 0, LS_NONE, 0);
    issue(EXE_DIVU_OP, 9, 4, LS_NONE, 0);
    issue(EXE_MFLO_OP, 0, 0, LS_NONE, 0);
    issue(EXE_MFHI_OP, 0, 0, LS_NONE, 0);
    issue(EXE_ADD_OP, 3, 4, LS_NONE, 0);

    @(posedge clk); #1;
    in_valid = 1'b0;
    ex_aluop = EXE_NOP_OP;
    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
